dog_extrema_detect: RTL and testbench

Consumes the five Gaussian-blurred pixel streams produced per pixel by the octave filter stage and forms four Difference-of-Gaussian (DoG) streams. It buffers two image rows per DoG level and flags SIFT keypoint candidates: strict 3x3x3 local extrema above a contrast threshold, on the two inner DoG scales. The block sits directly downstream of the octave filter and shares its `en` stall.

---
 rtl/dog_extrema_detect_if.sv | 27 ++
 rtl/dog_extrema_detect.sv | 190 +++++++++++++++++++
 tb/tb_dog_extrema_detect.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dog_extrema_detect_if.sv
// Pixel-stream bundle between the octave filter and the DoG extrema detector.
//   en, sof, dataIn               : accepted-pixel strobe, frame start, five packed Gaussian levels
//   dogOut, dogValid              : registered DoG levels and their one-cycle valid pulse
//   keyValid, keyMask, keyX, keyY : keypoint candidate pulse, scale mask and centre position
interface dog_extrema_detect_if #(
    parameter int unsigned dataW = 9
);
    logic                     en;
    logic                     sof;
    logic [5*dataW-1:0]       dataIn;
    logic [4*(dataW+1)-1:0]   dogOut;
    logic                     dogValid;
    logic                     keyValid;
    logic [1:0]               keyMask;
    logic [15:0]              keyX;
    logic [15:0]              keyY;

    modport master (
        output en, sof, dataIn,
        input  dogOut, dogValid, keyValid, keyMask, keyX, keyY
    );

    modport slave (
        input  en, sof, dataIn,
        output dogOut, dogValid, keyValid, keyMask, keyX, keyY
    );
endinterface

// File: rtl/dog_extrema_detect.sv
// Difference-of-Gaussian stage with 3x3x3 extremum detection on the two inner scales.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of dog_extrema_detect_if (pixel in, DoG and keypoint candidates out)
// Pipeline: stage 1 forms DoG + position, stage 2 line-buffers into 3x3 windows,
// stage 3 registers the extremum decision for the window centre (x-1, y-1).
module dog_extrema_detect #(
    parameter int unsigned dataW  = 9,
    parameter int unsigned imgW   = 640,
    parameter int unsigned imgH   = 480,
    parameter int unsigned thresh = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    dog_extrema_detect_if.slave  bus
);
    localparam int unsigned DW  = dataW + 1;
    localparam int unsigned X_W = (imgW > 1) ? $clog2(imgW) : 1;
    localparam logic [15:0] X_LAST = 16'(imgW - 1);
    localparam logic [15:0] Y_LAST = 16'(imgH - 1);
    localparam logic signed [DW-1:0] THR     = DW'(thresh);
    localparam logic signed [DW-1:0] NEG_THR = -THR;

    // Stage 1 state
    logic [15:0]      cnt_x_q, cnt_y_q;
    logic [1:0]       fill_q;
    logic [4*DW-1:0]  dog_q;
    logic             dog_valid_q;
    logic [15:0]      s1_x_q, s1_y_q;
    logic [1:0]       s1_fill_q;

    // Stage 2 state: window indexed [level][column: 0 newest][row: 0 oldest]
    logic signed [DW-1:0] win_q [4][3][3];
    logic [15:0]          w_x_q, w_y_q;
    logic [1:0]           w_fill_q;

    // Stage 3 outputs
    logic        key_valid_q;
    logic [1:0]  key_mask_q;
    logic [15:0] key_x_q, key_y_q;

    // Row memories (contents survive reset; border rejection hides stale data)
    logic [DW-1:0] lb1_q [4][imgW];
    logic [DW-1:0] lb2_q [4][imgW];

    logic [4*DW-1:0] dog_d;
    logic [15:0]     px, py, nx, ny;
    logic [1:0]      pf, nf;
    logic [X_W-1:0]  xi;
    logic [DW-1:0]   rd1 [4];
    logic [DW-1:0]   rd2 [4];
    logic [1:0]      mask_c;
    logic            border_ok_c;

    // DoG: zero-extended unsigned operands, so the DW-bit difference never overflows
    always_comb begin
        dog_d = '0;
        for (int k = 0; k < 4; k++) begin
            dog_d[k*DW +: DW] = {1'b0, bus.dataIn[(k+1)*dataW +: dataW]}
                              - {1'b0, bus.dataIn[k*dataW +: dataW]};
        end
    end

    // Position of the accepted pixel and the counter value for the next one
    always_comb begin
        px = bus.sof ? 16'd0 : cnt_x_q;
        py = bus.sof ? 16'd0 : cnt_y_q;
        pf = bus.sof ? 2'd0  : fill_q;
        nx = px + 16'd1;
        ny = py;
        nf = pf;
        if (px == X_LAST) begin
            nx = 16'd0;
            ny = (py == Y_LAST) ? 16'd0 : py + 16'd1;
            if (pf != 2'd2) begin
                nf = pf + 2'd1;
            end
        end
    end

    // Row y-1 and y-2 reads at the stage-1 column
    assign xi = s1_x_q[X_W-1:0];
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd1[k] = lb1_q[k][xi];
            rd2[k] = lb2_q[k][xi];
        end
    end

    // Read-before-write row rotation
    always_ff @(posedge clk) begin
        if (bus.en) begin
            for (int k = 0; k < 4; k++) begin
                lb1_q[k][xi] <= dog_q[k*DW +: DW];
                lb2_q[k][xi] <= rd1[k];
            end
        end
    end

    // Strict 26-neighbour extremum with contrast gate on D1 and D2
    always_comb begin : extremum
        logic signed [DW-1:0] c;
        logic                 is_max;
        logic                 is_min;
        mask_c = '0;
        c      = '0;
        is_max = 1'b0;
        is_min = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            c      = win_q[s][1][1];
            is_max = 1'b1;
            is_min = 1'b1;
            for (int k = s - 1; k <= s + 1; k++) begin
                for (int col = 0; col < 3; col++) begin
                    for (int row = 0; row < 3; row++) begin
                        if (!(k == s && col == 1 && row == 1)) begin
                            if (c <= win_q[k][col][row]) is_max = 1'b0;
                            if (c >= win_q[k][col][row]) is_min = 1'b0;
                        end
                    end
                end
            end
            mask_c[s-1] = (is_max || is_min) && ((c > THR) || (c < NEG_THR));
        end
    end

    // Centre (w-1) must be inside the 1-pixel border; upper bounds hold by construction
    assign border_ok_c = (w_x_q >= 16'd2) && (w_y_q >= 16'd2) && (w_fill_q == 2'd2);

    // Pipeline registers; valid pulses load 0 on stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            fill_q      <= '0;
            dog_q       <= '0;
            dog_valid_q <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_fill_q   <= '0;
            w_x_q       <= '0;
            w_y_q       <= '0;
            w_fill_q    <= '0;
            key_valid_q <= 1'b0;
            key_mask_q  <= '0;
            key_x_q     <= '0;
            key_y_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                for (int col = 0; col < 3; col++) begin
                    for (int row = 0; row < 3; row++) begin
                        win_q[k][col][row] <= '0;
                    end
                end
            end
        end else begin
            dog_valid_q <= bus.en;
            key_valid_q <= bus.en && (mask_c != 2'b00) && border_ok_c;
            if (bus.en) begin
                cnt_x_q   <= nx;
                cnt_y_q   <= ny;
                fill_q    <= nf;
                dog_q     <= dog_d;
                s1_x_q    <= px;
                s1_y_q    <= py;
                s1_fill_q <= pf;
                for (int k = 0; k < 4; k++) begin
                    for (int row = 0; row < 3; row++) begin
                        win_q[k][2][row] <= win_q[k][1][row];
                        win_q[k][1][row] <= win_q[k][0][row];
                    end
                    win_q[k][0][0] <= rd2[k];
                    win_q[k][0][1] <= rd1[k];
                    win_q[k][0][2] <= dog_q[k*DW +: DW];
                end
                w_x_q      <= s1_x_q;
                w_y_q      <= s1_y_q;
                w_fill_q   <= s1_fill_q;
                key_mask_q <= mask_c;
                key_x_q    <= w_x_q - 16'd1;
                key_y_q    <= w_y_q - 16'd1;
            end
        end
    end

    assign bus.dogOut   = dog_q;
    assign bus.dogValid = dog_valid_q;
    assign bus.keyValid = key_valid_q;
    assign bus.keyMask  = key_mask_q;
    assign bus.keyX     = key_x_q;
    assign bus.keyY     = key_y_q;
endmodule

// File: tb/tb_dog_extrema_detect.sv
// Directed bench for dog_extrema_detect on an 8x8 image.
module tb_dog_extrema_detect;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned IMG_W  = 8;
    localparam int unsigned IMG_H  = 8;
    localparam int unsigned THRESH = 3;
    localparam int          NPIX   = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dog_extrema_detect_if #(.dataW(DATA_W)) bus ();

    dog_extrema_detect #(
        .dataW (DATA_W),
        .imgW  (IMG_W),
        .imgH  (IMG_H),
        .thresh(THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered while driving
    int          en_cnt, dog_cnt, key_cnt, key_at, probe_idx;
    logic [15:0] key_x, key_y;
    logic [1:0]  key_mask;
    logic [39:0] probe_dog;
    bit          dog_nz, bad_dv;

    task automatic clear_obs();
        en_cnt = 0; dog_cnt = 0; key_cnt = 0; key_at = -1; probe_idx = -1;
        key_x = '0; key_y = '0; key_mask = '0; probe_dog = '0;
        dog_nz = 1'b0; bad_dv = 1'b0;
    endtask

    // One clock: drive, then sample #1 after the rising edge
    task automatic step(input logic e, input logic s, input logic [5*DATA_W-1:0] d);
        bus.en = e; bus.sof = s; bus.dataIn = d;
        @(posedge clk);
        #1;
        if (bus.dogValid) begin
            dog_cnt++;
            if (bus.dogOut != '0) dog_nz = 1'b1;
        end
        if (bus.dogValid != e) bad_dv = 1'b1;
        if (bus.keyValid) begin
            key_cnt++;
            key_x = bus.keyX; key_y = bus.keyY; key_mask = bus.keyMask; key_at = en_cnt;
        end
        if (e && en_cnt == probe_idx) probe_dog = bus.dogOut;
        if (e) en_cnt++;
    endtask

    // Frame with up to two G2 spots, followed by flush pixels when n_pix > NPIX
    task automatic run_frame(input int base, input int sx, input int sy, input int amp,
                             input int sx2, input int sy2, input bit stall, input int n_pix);
        for (int idx = 0; idx < n_pix; idx++) begin
            int x, y, g2;
            logic [5*DATA_W-1:0] d;
            x  = (idx % NPIX) % IMG_W;
            y  = (idx % NPIX) / IMG_W;
            g2 = base;
            if (idx < NPIX && x == sx  && y == sy ) g2 += amp;
            if (idx < NPIX && x == sx2 && y == sy2) g2 += amp;
            d = {9'(base), 9'(base), 9'(g2), 9'(base), 9'(base)};
            if (stall) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, d);
            step(1'b1, idx == 0, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b0, 45'h1234_5678_9AB);
        checks++; if (bus.dogOut !== '0)   begin errors++; $display("FAIL reset_dogOut: got %h expected 0", bus.dogOut); end
        checks++; if (bus.dogValid !== 1'b0) begin errors++; $display("FAIL reset_dogValid: got %b expected 0", bus.dogValid); end
        checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("FAIL reset_keyValid: got %b expected 0", bus.keyValid); end
        checks++; if (bus.keyMask !== 2'b00) begin errors++; $display("FAIL reset_keyMask: got %b expected 00", bus.keyMask); end
        checks++; if (bus.keyX !== 16'd0)    begin errors++; $display("FAIL reset_keyX: got %0d expected 0", bus.keyX); end
        checks++; if (bus.keyY !== 16'd0)    begin errors++; $display("FAIL reset_keyY: got %0d expected 0", bus.keyY); end
        rst = 1'b0;
    endtask

    task automatic test_flat();
        clear_obs();
        run_frame(100, -1, -1, 0, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 0) begin errors++; $display("FAIL flat_keys: got %0d expected 0", key_cnt); end
        checks++; if (dog_nz)        begin errors++; $display("FAIL flat_dog_zero: got nonzero expected 0"); end
        checks++; if (dog_cnt != en_cnt) begin errors++; $display("FAIL flat_dogValid_count: got %0d expected %0d", dog_cnt, en_cnt); end
    endtask

    task automatic test_single_spot();
        logic [39:0] exp_dog;
        exp_dog = {10'd0, 10'h3D8, 10'd40, 10'd0};
        clear_obs();
        probe_idx = 4 * IMG_W + 4;
        run_frame(10, 4, 4, 40, -1, -1, 1'b0, NPIX + 3);
        checks++; if (probe_dog !== exp_dog) begin errors++; $display("FAIL spot_dogOut: got %h expected %h", probe_dog, exp_dog); end
        checks++; if (key_cnt != 1)      begin errors++; $display("FAIL spot_keys: got %0d expected 1", key_cnt); end
        checks++; if (key_mask !== 2'b11) begin errors++; $display("FAIL spot_mask: got %b expected 11", key_mask); end
        checks++; if (key_x !== 16'd4)   begin errors++; $display("FAIL spot_x: got %0d expected 4", key_x); end
        checks++; if (key_y !== 16'd4)   begin errors++; $display("FAIL spot_y: got %0d expected 4", key_y); end
        checks++; if (key_at != 47)      begin errors++; $display("FAIL spot_latency: got %0d expected 47", key_at); end
    endtask

    task automatic test_threshold();
        clear_obs();
        run_frame(10, 4, 4, 3, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 0) begin errors++; $display("FAIL thr3_keys: got %0d expected 0", key_cnt); end
        clear_obs();
        run_frame(10, 4, 4, 4, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 1)       begin errors++; $display("FAIL thr4_keys: got %0d expected 1", key_cnt); end
        checks++; if (key_mask !== 2'b11) begin errors++; $display("FAIL thr4_mask: got %b expected 11", key_mask); end
        checks++; if (key_x !== 16'd4 || key_y !== 16'd4) begin errors++; $display("FAIL thr4_pos: got (%0d,%0d) expected (4,4)", key_x, key_y); end
    endtask

    task automatic test_border_tie();
        clear_obs();
        run_frame(10, 0, 3, 40, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 0) begin errors++; $display("FAIL border_left_keys: got %0d expected 0", key_cnt); end
        clear_obs();
        run_frame(10, 7, 7, 40, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 0) begin errors++; $display("FAIL border_corner_keys: got %0d expected 0", key_cnt); end
        clear_obs();
        run_frame(10, 4, 4, 40, 3, 4, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 0) begin errors++; $display("FAIL tie_keys: got %0d expected 0", key_cnt); end
    endtask

    task automatic test_random_stall();
        clear_obs();
        run_frame(10, 4, 4, 40, -1, -1, 1'b1, NPIX + 3);
        checks++; if (key_cnt != 1)       begin errors++; $display("FAIL stall_keys: got %0d expected 1", key_cnt); end
        checks++; if (key_mask !== 2'b11) begin errors++; $display("FAIL stall_mask: got %b expected 11", key_mask); end
        checks++; if (key_x !== 16'd4 || key_y !== 16'd4) begin errors++; $display("FAIL stall_pos: got (%0d,%0d) expected (4,4)", key_x, key_y); end
        checks++; if (key_at != 47)       begin errors++; $display("FAIL stall_latency: got %0d expected 47", key_at); end
        checks++; if (dog_cnt != NPIX + 3) begin errors++; $display("FAIL stall_dogValid_count: got %0d expected %0d", dog_cnt, NPIX + 3); end
        checks++; if (bad_dv)             begin errors++; $display("FAIL stall_dogValid_pulse: got pulse on stalled cycle expected none"); end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        run_frame(10, 2, 1, 40, -1, -1, 1'b0, 21);
        rst = 1'b1;
        repeat (2) step(1'b1, 1'b0, 45'h0);
        checks++; if (bus.dogValid !== 1'b0 || bus.keyValid !== 1'b0) begin errors++; $display("FAIL midrst_valids: got %b%b expected 00", bus.dogValid, bus.keyValid); end
        checks++; if (bus.keyX !== 16'd0 || bus.dogOut !== '0) begin errors++; $display("FAIL midrst_outputs: got keyX=%0d dogOut=%h expected 0", bus.keyX, bus.dogOut); end
        rst = 1'b0;
        clear_obs();
        run_frame(10, 4, 4, 40, -1, -1, 1'b0, NPIX + 3);
        checks++; if (key_cnt != 1)  begin errors++; $display("FAIL midrst_keys: got %0d expected 1", key_cnt); end
        checks++; if (key_x !== 16'd4 || key_y !== 16'd4) begin errors++; $display("FAIL midrst_pos: got (%0d,%0d) expected (4,4)", key_x, key_y); end
        checks++; if (key_at != 47)  begin errors++; $display("FAIL midrst_latency: got %0d expected 47", key_at); end
    endtask

    initial begin
        bus.en = 1'b0; bus.sof = 1'b0; bus.dataIn = '0;
        clear_obs();
        test_reset();
        test_flat();
        test_single_spot();
        test_threshold();
        test_border_tie();
        test_random_stall();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
